// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter sharing one combinational multiplier among NUM_REQ requesters.
// The operand and output registers form a two-stage pipeline; the response carries the requester id.
module myproject_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 12,
    parameter int DOUT_WIDTH = 21,
    parameter int ID_WIDTH   = 2
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic [DIN0_WIDTH-1:0]            mul_din0,
    output logic [DIN1_WIDTH-1:0]            mul_din1,
    input  logic [DOUT_WIDTH-1:0]            mul_dout,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic [ID_WIDTH-1:0]              rsp_id
);

    logic                  r_op_v;
    logic [DIN0_WIDTH-1:0] r_op_din0;
    logic [DIN1_WIDTH-1:0] r_op_din1;
    logic [ID_WIDTH-1:0]   r_op_id;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic                  r_rsp_valid;
    logic [DOUT_WIDTH-1:0] r_rsp_dout;
    logic [ID_WIDTH-1:0]   r_rsp_id;

    logic                  w_out_en;
    logic                  w_acc_en;
    logic                  w_gnt_any;
    logic [ID_WIDTH-1:0]   w_gnt_id;
    logic                  w_xfer;
    logic [ID_WIDTH-1:0]   w_ptr_nxt;
    logic [DIN0_WIDTH-1:0] w_sel_din0;
    logic [DIN1_WIDTH-1:0] w_sel_din1;

    assign w_out_en = !r_rsp_valid || rsp_ready;
    assign w_acc_en = !r_op_v || w_out_en;

    // Search starts at the pointer and wraps modulo NUM_REQ, so non-power-of-two counts work too.
    always_comb begin
        int v_idx;
        w_gnt_any  = 1'b0;
        w_gnt_id   = '0;
        w_sel_din0 = '0;
        w_sel_din1 = '0;
        v_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_gnt_any && req_valid[v_idx]) begin
                w_gnt_any  = 1'b1;
                w_gnt_id   = ID_WIDTH'(v_idx);
                w_sel_din0 = req_din0[v_idx*DIN0_WIDTH +: DIN0_WIDTH];
                w_sel_din1 = req_din1[v_idx*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    // Reset gates the grant directly so req_ready is low while ap_rst_n is asserted.
    assign w_xfer    = ap_rst_n && w_acc_en && w_gnt_any;
    assign req_ready = w_xfer ? (NUM_REQ'(1) << w_gnt_id) : '0;
    assign w_ptr_nxt = (w_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_WIDTH'(1);

    // Idle operands are forced to zero to keep the DSP quiet.
    assign mul_din0 = r_op_v ? r_op_din0 : '0;
    assign mul_din1 = r_op_v ? r_op_din1 : '0;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_op_v      <= 1'b0;
            r_op_din0   <= '0;
            r_op_din1   <= '0;
            r_op_id     <= '0;
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dout  <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (w_xfer) begin
                r_op_v    <= 1'b1;
                r_op_din0 <= w_sel_din0;
                r_op_din1 <= w_sel_din1;
                r_op_id   <= w_gnt_id;
                r_ptr     <= w_ptr_nxt;
            end else if (w_out_en) begin
                r_op_v    <= 1'b0;
            end
            if (w_out_en) begin
                r_rsp_valid <= r_op_v;
                if (r_op_v) begin
                    r_rsp_dout <= mul_dout;
                    r_rsp_id   <= r_op_id;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_dout  = r_rsp_dout;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Bench for myproject_mul_share_arb: table vectors, directed corner sequences and a
// randomized run checked against a queue-based transaction model.
module tb_myproject_mul_share_arb;

    localparam int N = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*9-1:0]  req_din0;
    logic [N*12-1:0] req_din1;
    logic [8:0]    mul_din0;
    logic [11:0]   mul_din1;
    logic [20:0]   mul_dout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [20:0]   rsp_dout;
    logic [1:0]    rsp_id;

    myproject_mul_share_arb dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_din0 (req_din0),
        .req_din1 (req_din1),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dout (rsp_dout),
        .rsp_id   (rsp_id)
    );

    // External shared multiplier: unsigned x signed, exact in 21 bits.
    logic [20:0] w_ma, w_mb;
    assign w_ma = {12'b0, mul_din0};
    assign w_mb = {{9{mul_din1[11]}}, mul_din1};
    assign mul_dout = $signed(w_ma) * $signed(w_mb);

    always #5 ap_clk = ~ap_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint prod(input logic [8:0] a, input logic [11:0] b);
        return longint'(a) * longint'($signed(b));
    endfunction

    // Transaction model: accepted operations in order, with the cycle of acceptance.
    typedef struct {
        int     id;
        longint p;
        int     acc;
    } ent_t;
    ent_t      q[$];
    int        m_ptr = 0;
    int        cyc = 0;
    int        n_xfer = 0;
    logic [N-1:0] last_xfer = '0;

    always @(negedge ap_clk) begin
        logic [N-1:0] exp_rdy;
        logic         found;
        logic         exp_v;
        int           j;
        cyc++;
        last_xfer = '0;
        if (ap_rst_n) begin
            exp_rdy = '0;
            found   = 1'b0;
            // Two operations in flight with a stalled consumer means the pipe is full.
            if (!(q.size() == 2 && !rsp_ready)) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (!found && req_valid[j]) begin
                        exp_rdy[j] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            chk("mon_ready", longint'(req_ready), longint'(exp_rdy));
            exp_v = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("mon_rsp_valid", longint'(rsp_valid), longint'(exp_v));
            if (rsp_valid && q.size() > 0) begin
                chk("mon_rsp_dout", longint'($signed(rsp_dout)), q[0].p);
                chk("mon_rsp_id", longint'(rsp_id), longint'(q[0].id));
                if (rsp_ready) void'(q.pop_front());
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q.push_back('{i, prod(req_din0[i*9 +: 9], req_din1[i*12 +: 12]), cyc});
                    m_ptr = (i + 1) % N;
                    last_xfer[i] = 1'b1;
                    n_xfer++;
                end
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        q.delete();
        m_ptr = 0;
        step();
        step();
        ap_rst_n = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    typedef struct {
        logic [8:0]  d0;
        logic [11:0] d1;
        int          exp;
    } vec_t;
    vec_t vecs[7];

    initial begin
        logic [20:0] held_dout;
        logic [1:0]  held_id;
        int          x0;

        vecs[0] = '{9'd3,   12'hFFB, -15};
        vecs[1] = '{9'd511, 12'h800, -1046528};
        vecs[2] = '{9'd511, 12'h7FF, 1046017};
        vecs[3] = '{9'd0,   12'h4D2, 0};
        vecs[4] = '{9'd1,   12'hFFF, -1};
        vecs[5] = '{9'd100, 12'hF9C, -10000};
        vecs[6] = '{9'd255, 12'h7FF, 521985};

        ap_rst_n  = 1'b0;
        req_valid = '1;
        req_din0  = '0;
        req_din1  = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests pending to show req_ready is gated.
        @(negedge ap_clk);
        chk("rst_rsp_valid", longint'(rsp_valid), 0);
        chk("rst_rsp_dout", longint'(rsp_dout), 0);
        chk("rst_rsp_id", longint'(rsp_id), 0);
        chk("rst_req_ready", longint'(req_ready), 0);
        chk("rst_mul_din0", longint'(mul_din0), 0);
        chk("rst_mul_din1", longint'(mul_din1), 0);
        step();
        req_valid = '0;
        ap_rst_n  = 1'b1;

        // Table vectors through requester 0.
        foreach (vecs[v]) begin
            req_din0[8:0]  = vecs[v].d0;
            req_din1[11:0] = vecs[v].d1;
            req_valid      = 4'b0001;
            rsp_ready      = 1'b1;
            @(negedge ap_clk);
            chk("vec_ready", longint'(req_ready), 1);
            step();
            req_valid = '0;
            @(negedge ap_clk);
            chk("vec_lat_early", longint'(rsp_valid), 0);
            @(negedge ap_clk);
            chk("vec_lat_valid", longint'(rsp_valid), 1);
            chk("vec_dout", longint'($signed(rsp_dout)), longint'(vecs[v].exp));
            chk("vec_id", longint'(rsp_id), 0);
            step();
        end

        // All requesters valid: strict rotation, one per cycle, no response gaps.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_din0[i*9 +: 9]   = 9'(i * 37 + 5);
            req_din1[i*12 +: 12] = 12'(-(i * 301 + 7));
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge ap_clk);
            chk("rr_grant", longint'(onehot_idx(req_ready)), longint'(k % N));
            if (k >= 2) begin
                chk("rr_rsp_valid", longint'(rsp_valid), 1);
                chk("rr_rsp_id", longint'(rsp_id), longint'((k - 2) % N));
            end
        end
        step();
        req_valid = '0;
        repeat (4) step();

        // Backpressure from an empty pipe: exactly two accepted, then stall with stable output.
        req_valid = '1;
        rsp_ready = 1'b0;
        x0 = n_xfer;
        held_dout = '0;
        held_id   = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            if (k >= 2) begin
                chk("bp_ready_zero", longint'(req_ready), 0);
                chk("bp_valid", longint'(rsp_valid), 1);
            end
            if (k == 2) begin
                held_dout = rsp_dout;
                held_id   = rsp_id;
            end
            if (k > 2) begin
                chk("bp_dout_hold", longint'(rsp_dout), longint'(held_dout));
                chk("bp_id_hold", longint'(rsp_id), longint'(held_id));
            end
            step();
        end
        chk("bp_inflight", longint'(n_xfer - x0), 2);
        rsp_ready = 1'b1;
        repeat (6) step();
        req_valid = '0;
        repeat (4) step();
        chk("bp_drained", longint'(q.size()), 0);

        // Pointer moves past req2, so req3 beats req0.
        do_reset();
        req_valid = 4'b0100;
        @(negedge ap_clk);
        chk("fair_g2", longint'(req_ready), 4'b0100);
        step();
        req_valid = 4'b1001;
        @(negedge ap_clk);
        chk("fair_g3", longint'(req_ready), 4'b1000);
        step();
        @(negedge ap_clk);
        chk("fair_g0", longint'(req_ready), 4'b0001);
        step();
        req_valid = '0;
        repeat (4) step();

        // Asynchronous reset between edges while a response is valid.
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (3) step();
        @(negedge ap_clk);
        chk("ar_pre_valid", longint'(rsp_valid), 1);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", longint'(rsp_valid), 0);
        chk("ar_req_ready", longint'(req_ready), 0);
        chk("ar_mul_din0", longint'(mul_din0), 0);
        chk("ar_mul_din1", longint'(mul_din1), 0);
        q.delete();
        m_ptr = 0;
        step();
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("ar_first_grant", longint'(req_ready), 4'b0001);
        step();
        req_valid = '0;
        repeat (4) step();

        // Random traffic: operands stay stable while pending; withdrawal is allowed.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !last_xfer[i]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    case ($urandom_range(0, 7))
                        0:       begin req_din0[i*9 +: 9] = 9'd511; req_din1[i*12 +: 12] = 12'h800; end
                        1:       begin req_din0[i*9 +: 9] = 9'd511; req_din1[i*12 +: 12] = 12'h7FF; end
                        default: begin
                            req_din0[i*9 +: 9]   = 9'($urandom);
                            req_din1[i*12 +: 12] = 12'($urandom);
                        end
                    endcase
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        chk("final_drained", longint'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
